// File: rtl/instr_encoder_pkg.sv
// Shared ISA constants: instruction kinds, opcodes, field bit positions and
// the word encoder used by both the encoder datapath and the control decoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_R    = 3'd0,
    KIND_ADDI = 3'd1,
    KIND_SUBI = 3'd2,
    KIND_SW   = 3'd3,
    KIND_LW   = 3'd4,
    KIND_BEQ  = 3'd5,
    KIND_J    = 3'd6,
    KIND_RSVD = 3'd7
  } kind_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001100;
  localparam logic [5:0] OP_SUBI = 6'b001101;
  localparam logic [5:0] OP_SW   = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b010001;
  localparam logic [5:0] OP_BEQ  = 6'b010011;
  localparam logic [5:0] OP_J    = 6'b011100;

  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  // Occupancy counter width; sized for DEPTH up to 7.
  localparam int COUNT_W = 3;

  function automatic logic [5:0] i_opcode(input kind_e kind);
    logic [5:0] op;
    case (kind)
      KIND_ADDI: op = OP_ADDI;
      KIND_SUBI: op = OP_SUBI;
      KIND_SW:   op = OP_SW;
      KIND_LW:   op = OP_LW;
      KIND_BEQ:  op = OP_BEQ;
      default:   op = OP_R;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] encode_instr(
    input kind_e       kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      KIND_R: begin
        w[OP_LSB +: 6]    = OP_R;
        w[RS_LSB +: 5]    = rs;
        w[RT_LSB +: 5]    = rt;
        w[RD_LSB +: 5]    = rd;
        w[SHAMT_LSB +: 5] = shamt;
        w[FUNCT_LSB +: 6] = funct;
      end
      KIND_J: begin
        w[OP_LSB +: 6]      = OP_J;
        w[TARGET_LSB +: 26] = target;
      end
      KIND_RSVD: w = '0;
      default: begin
        w[OP_LSB +: 6]   = i_opcode(kind);
        w[RS_LSB +: 5]   = rs;
        w[RT_LSB +: 5]   = rt;
        w[IMM_LSB +: 16] = imm;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous DEPTH-entry FIFO holding encoded instruction words; the head
// entry is presented combinationally so a pushed word is visible one edge later.
module instr_fifo
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic [COUNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               do_push;
  logic               do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && !rst && (count_reg < COUNT_W'(DEPTH));
  assign do_pop  = pop && !rst && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + COUNT_W'(1);
        2'b01:   count_reg <= count_reg - COUNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction field bundles into 32-bit words, queues them in a FIFO,
// and tags each emitted word with a running byte address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [2:0]        count,
  output logic              err
);

  logic              accept;
  logic              push;
  logic              pop;
  logic              rsvd;
  logic [31:0]       word;
  logic              err_reg;
  logic [ADDR_W-1:0] addr_reg;

  // in_ready depends only on occupancy: a full FIFO never passes through.
  assign in_ready  = count < COUNT_W'(DEPTH);
  assign out_valid = count != '0;

  assign rsvd   = kind_e'(in_kind) == KIND_RSVD;
  assign accept = in_valid && in_ready && !rst;
  assign push   = accept && !rsvd;
  assign pop    = out_valid && out_ready && !rst;

  assign word = encode_instr(kind_e'(in_kind), in_rs, in_rt, in_rd, in_shamt,
                             in_funct, in_imm, in_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg  <= 1'b0;
      addr_reg <= '0;
    end else begin
      err_reg <= accept && rsvd;
      if (pop) begin
        addr_reg <= addr_reg + ADDR_W'(4);
      end
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .rdata (out_instr),
    .count (count)
  );

  assign out_addr = addr_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard queue of expected words,
// immediate assertions at every comparison point.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [2:0]        in_kind = '0;
  logic [4:0]        in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]        in_funct = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              in_ready, out_valid, err;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [2:0]        count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = '0;
  logic [31:0] cur_exp = '0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: score any output handshake before the edge, then update the
  // model and check the registered state just after it.
  task automatic tick(input string tag);
    logic ih, oh, exp_err;
    ih = in_valid && in_ready;
    oh = out_valid && out_ready;
    if (!rst) begin
      chk({tag, ":in_ready"}, 32'(in_ready), 32'(exp_q.size() < DEPTH));
      if (oh && exp_q.size() > 0) begin
        chk({tag, ":out_instr"}, out_instr, exp_q.pop_front());
        chk({tag, ":out_addr"}, out_addr, exp_addr);
        exp_addr += 32'd4;
      end
    end
    exp_err = ih && !rst && (in_kind == 3'd7);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_addr = '0;
    end else if (ih && in_kind != 3'd7) begin
      exp_q.push_back(cur_exp);
    end
    chk({tag, ":err"}, 32'(err), 32'(exp_err));
    chk({tag, ":count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, ":out_valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
    chk({tag, ":addr_hold"}, out_addr, exp_addr);
    if (exp_q.size() > 0) chk({tag, ":head"}, out_instr, exp_q[0]);
  endtask

  task automatic offer(input string tag, input logic [2:0] k, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tg, input logic [31:0] exp);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tg;
    cur_exp = exp;
    in_valid = 1'b1;
    tick(tag);
    in_valid = 1'b0;
    in_kind = 3'($urandom); in_rs = 5'($urandom); in_imm = 16'($urandom);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    tick(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick("rst0");
    tick("rst1");
    rst = 1'b0;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_addr", out_addr, 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // ADDI with one-cycle latency
    out_ready = 1'b1;
    offer("addi", 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 32'h30220005);
    chk("addi_latency_valid", 32'(out_valid), 32'd1);
    chk("addi_latency_instr", out_instr, 32'h30220005);
    chk("addi_latency_addr", out_addr, 32'h0);
    idle("addi_drain");

    // R then J, J leaves at address 0x4
    do_reset("rst_rj");
    out_ready = 1'b1;
    offer("r_type", 3'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20, 16'd0, 26'd0, 32'h00642820);
    offer("j_type", 3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 32'h70000010);
    chk("j_head_addr", out_addr, 32'h4);
    chk("j_head_instr", out_instr, 32'h70000010);
    idle("rj_drain");

    // SW, BEQ, SUBI, LW
    offer("sw", 3'd3, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 32'h43A8FFFC);
    offer("beq", 3'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0003, 26'd0, 32'h4C220003);
    offer("subi", 3'd2, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 32'h34220005);
    offer("lw", 3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 32'h44220005);
    idle("i_drain");

    // Fill with sink stalled, 5th bundle refused, then drain in order
    do_reset("rst_full");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      offer("fill", 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i + 1), 26'd0, 32'h30220000 | 32'(i + 1));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle("drain");
    chk("drain_final_addr", out_addr, 32'h10);

    // Reserved kind: err pulse, nothing queued
    do_reset("rst_rsvd");
    out_ready = 1'b0;
    offer("pre_rsvd", 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0007, 26'd0, 32'h30220007);
    offer("rsvd", 3'd7, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 26'h3FFFFFF, 32'hDEADBEEF);
    chk("rsvd_err_high", 32'(err), 32'd1);
    chk("rsvd_count", 32'(count), 32'd1);
    idle("rsvd_after");
    chk("rsvd_err_low", 32'(err), 32'd0);
    out_ready = 1'b1;
    idle("rsvd_drain");

    // Reset during traffic with a bundle offered
    do_reset("rst_mid");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      offer("pre_mid", 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i + 8), 26'd0, 32'h30220008 + 32'(i));
    chk("mid_count3", 32'(count), 32'd3);
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_kind = 3'd1; cur_exp = 32'hBAD0BAD0;
    tick("mid_rst");
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_addr", out_addr, 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    offer("post_mid", 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 32'h30220005);
    chk("post_mid_addr", out_addr, 32'd0);
    idle("post_mid_drain");

    // Back-to-back stream: simultaneous push/pop, pointers wrap
    for (int i = 0; i < 9; i++)
      offer("stream", 3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(16'h100 + i), 26'd0, 32'h30220100 + 32'(i));
    idle("stream_drain");
    idle("stream_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
